// File: rtl/execute_alu_mc.sv
// Multi-cycle execute-stage ALU: RV32I base, branch-compare and address ops
// complete in one cycle. RV32M multiply waits a fixed MUL_LAT cycles.
// Divide is a restoring, one-bit-per-cycle divider.
module execute_alu_mc #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_vld,
  output logic            in_rdy,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic            funct7_0,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_vld,
  input  logic            out_rdy,
  output logic [XLEN-1:0] y,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);
  localparam int DCW = $clog2(XLEN);
  localparam int MCW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RR     = 7'b0110011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_reg, state_next, launch_state;

  logic [2*XLEN-1:0] prod_reg;
  logic              mul_hi_reg;
  logic [MCW-1:0]    mul_cnt_reg;
  logic [DCW-1:0]    div_cnt_reg;
  logic [XLEN-1:0]   rem_reg;
  logic [XLEN-1:0]   quo_reg;
  logic [XLEN-1:0]   dsr_reg;
  logic              neg_q_reg;
  logic              neg_r_reg;
  logic              rem_sel_reg;
  logic [XLEN-1:0]   y_reg;

  logic accept;

  assign in_rdy  = ~flush & ((state_reg == S_IDLE) | ((state_reg == S_DONE) & out_rdy));
  assign accept  = in_vld & in_rdy;
  assign out_vld = (state_reg == S_DONE);
  assign busy    = (state_reg != S_IDLE);
  assign y       = y_reg;

  // ---------------- single-cycle base datapath ----------------
  logic [SHW-1:0]  shamt;
  logic            lt_s, lt_u;
  logic [XLEN-1:0] sum_res, sub_res, sll_res, srl_res, sra_res, slt_res, sltu_res;
  logic [XLEN-1:0] base_y;

  assign shamt    = b[SHW-1:0];
  assign lt_s     = $signed(a) < $signed(b);
  assign lt_u     = a < b;
  assign sum_res  = a + b;
  assign sub_res  = a - b;
  assign sll_res  = a << shamt;
  assign srl_res  = a >> shamt;
  assign sra_res  = $signed(a) >>> shamt;
  assign slt_res  = {{(XLEN-1){1'b0}}, lt_s};
  assign sltu_res = {{(XLEN-1){1'b0}}, lt_u};

  // Decode the one-cycle result from opcode/funct fields.
  always_comb begin
    base_y = '0;
    case (opcode)
      OP_LOAD, OP_STORE: base_y = sum_res;
      OP_BRANCH: begin
        case (funct3[2:1])
          2'b00:   base_y = a ^ b;
          2'b10:   base_y = slt_res;
          2'b11:   base_y = sltu_res;
          default: base_y = '0;
        endcase
      end
      OP_RR: begin
        case ({funct7_5, funct3})
          4'b0000: base_y = sum_res;
          4'b1000: base_y = sub_res;
          4'b0001: base_y = sll_res;
          4'b0010: base_y = slt_res;
          4'b0011: base_y = sltu_res;
          4'b0100: base_y = a ^ b;
          4'b0101: base_y = srl_res;
          4'b1101: base_y = sra_res;
          4'b0110: base_y = a | b;
          4'b0111: base_y = a & b;
          default: base_y = '0;
        endcase
      end
      default: begin
        case (funct3)
          3'b000:  base_y = sum_res;
          3'b001:  base_y = sll_res;
          3'b010:  base_y = slt_res;
          3'b011:  base_y = sltu_res;
          3'b100:  base_y = a ^ b;
          3'b101:  base_y = funct7_5 ? sra_res : srl_res;
          3'b110:  base_y = a | b;
          default: base_y = a & b;
        endcase
      end
    endcase
  end

  // ---------------- M-extension setup at acceptance ----------------
  logic is_m, is_mul, is_div;
  assign is_m   = (opcode == OP_RR) & funct7_0;
  assign is_mul = is_m & ~funct3[2];
  assign is_div = is_m & funct3[2];

  // MULH and MULHSU treat a as signed; only MULH treats b as signed.
  logic              a_mul_signed, b_mul_signed;
  logic [2*XLEN-1:0] a_ext, b_ext, prod;
  assign a_mul_signed = (funct3[1:0] == 2'b01) | (funct3[1:0] == 2'b10);
  assign b_mul_signed = (funct3[1:0] == 2'b01);
  assign a_ext = {{XLEN{a_mul_signed & a[XLEN-1]}}, a};
  assign b_ext = {{XLEN{b_mul_signed & b[XLEN-1]}}, b};
  assign prod  = a_ext * b_ext;

  // DIV/REM are signed (funct3[0]=0); the divider works on magnitudes.
  logic            div_signed, a_neg, b_neg, b_zero, div_ovf, div_special;
  logic [XLEN-1:0] a_mag, b_mag, min_val, special_y;
  assign div_signed  = ~funct3[0];
  assign a_neg       = div_signed & a[XLEN-1];
  assign b_neg       = div_signed & b[XLEN-1];
  assign a_mag       = a_neg ? -a : a;
  assign b_mag       = b_neg ? -b : b;
  assign min_val     = {1'b1, {(XLEN-1){1'b0}}};
  assign b_zero      = (b == '0);
  assign div_ovf     = div_signed & (a == min_val) & (&b);
  assign div_special = b_zero | div_ovf;

  // Results for divide-by-zero and signed overflow, which bypass the divider.
  always_comb begin
    special_y = '0;
    if (b_zero) special_y = funct3[1] ? a : '1;
    else        special_y = funct3[1] ? '0 : a;
  end

  // ---------------- restoring divide step ----------------
  logic [XLEN:0]   rem_sh, rem_diff;
  logic            q_bit;
  logic [XLEN-1:0] rem_new, quo_new, div_q, div_r;
  assign rem_sh   = {rem_reg, quo_reg[XLEN-1]};
  assign rem_diff = rem_sh - {1'b0, dsr_reg};
  assign q_bit    = ~rem_diff[XLEN];
  assign rem_new  = q_bit ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quo_new  = {quo_reg[XLEN-2:0], q_bit};
  assign div_q    = neg_q_reg ? -quo_new : quo_new;
  assign div_r    = neg_r_reg ? -rem_new : rem_new;

  assign launch_state = is_mul ? S_MUL : ((is_div & ~div_special) ? S_DIV : S_DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; flush overrides everything except reset.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (accept) state_next = launch_state;
      S_MUL:  if (mul_cnt_reg == '0) state_next = S_DONE;
      S_DIV:  if (div_cnt_reg == '0) state_next = S_DONE;
      S_DONE: if (out_rdy) state_next = accept ? launch_state : S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (flush) state_next = S_IDLE;
  end

  // Operand capture, multiply/divide progress and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_reg    <= '0;
      mul_hi_reg  <= 1'b0;
      mul_cnt_reg <= '0;
      div_cnt_reg <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      dsr_reg     <= '0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      rem_sel_reg <= 1'b0;
      y_reg       <= '0;
    end else if (!flush) begin
      if (accept) begin
        if (is_mul) begin
          prod_reg    <= prod;
          mul_hi_reg  <= (funct3[1:0] != 2'b00);
          mul_cnt_reg <= MCW'(MUL_LAT - 1);
        end else if (is_div) begin
          if (div_special) begin
            y_reg <= special_y;
          end else begin
            rem_reg     <= '0;
            quo_reg     <= a_mag;
            dsr_reg     <= b_mag;
            neg_q_reg   <= a_neg ^ b_neg;
            neg_r_reg   <= a_neg;
            rem_sel_reg <= funct3[1];
            div_cnt_reg <= DCW'(XLEN - 1);
          end
        end else begin
          y_reg <= base_y;
        end
      end else if (state_reg == S_MUL) begin
        if (mul_cnt_reg == '0) y_reg <= mul_hi_reg ? prod_reg[2*XLEN-1:XLEN] : prod_reg[XLEN-1:0];
        else                   mul_cnt_reg <= mul_cnt_reg - 1'b1;
      end else if (state_reg == S_DIV) begin
        rem_reg <= rem_new;
        quo_reg <= quo_new;
        if (div_cnt_reg == '0) y_reg <= rem_sel_reg ? div_r : div_q;
        else                   div_cnt_reg <= div_cnt_reg - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_execute_alu_mc.sv
// Scoreboard bench for execute_alu_mc: stimulus pushes expected results,
// a negedge monitor pops and compares on every out_vld & out_rdy.
module tb_execute_alu_mc;
  localparam int XLEN    = 32;
  localparam int MUL_LAT = 2;

  localparam logic [6:0] OP_RR  = 7'b0110011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  logic            clk = 1'b0;
  logic            rst, flush, in_vld, in_rdy;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            funct7_5, funct7_0;
  logic [XLEN-1:0] a, b, y;
  logic            out_vld, out_rdy, busy;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  execute_alu_mc #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_vld(in_vld), .in_rdy(in_rdy),
    .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5), .funct7_0(funct7_0),
    .a(a), .b(b),
    .out_vld(out_vld), .out_rdy(out_rdy), .y(y), .busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every consumed result is compared against the oldest expectation.
  always @(negedge clk) begin
    string       nm;
    logic [31:0] e;
    if (!rst && out_vld && out_rdy) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got=0x%08h want=none", y);
      end else begin
        nm = name_q.pop_front();
        e  = exp_q.pop_front();
        $display("txn %-10s y=0x%08h exp=0x%08h", nm, y, e);
        chk(nm, y, e);
      end
    end
  end

  // Present a request until accepted; optionally record its expected result.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f75, input logic f70,
                       input logic [31:0] av, input logic [31:0] bv, input bit push,
                       input logic [31:0] ev, input string nm);
    int n = 0;
    opcode = op; funct3 = f3; funct7_5 = f75; funct7_0 = f70; a = av; b = bv; in_vld = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_rdy && n < 200);
    if (!in_rdy) begin
      total++;
      bad++;
      $display("FAIL %s_accept: in_rdy=0 want=1 (timeout)", nm);
      in_vld = 1'b0;
      return;
    end
    @(posedge clk);
    if (push) begin
      exp_q.push_back(ev);
      name_q.push_back(nm);
    end
    #1 in_vld = 1'b0;
  endtask

  // Issue one op with out_rdy=1 and check its result latency.
  task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic f75, input logic f70,
                     input logic [31:0] av, input logic [31:0] bv, input logic [31:0] ev,
                     input string nm, input int exp_lat);
    int lat = 0;
    bit rdy_seen = 1'b0;
    issue(op, f3, f75, f70, av, bv, 1'b1, ev, nm);
    do begin
      @(negedge clk);
      lat++;
      if (!out_vld && in_rdy) rdy_seen = 1'b1;
    end while (!out_vld && lat < 100);
    chk({nm, "_lat"}, 32'(lat), 32'(exp_lat));
    if (exp_lat > 1) chk({nm, "_rdy_low"}, 32'(rdy_seen), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    int n;
    rst = 1'b1; flush = 1'b0; in_vld = 1'b0; out_rdy = 1'b1;
    opcode = '0; funct3 = '0; funct7_5 = 1'b0; funct7_0 = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_y", y, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_rdy", 32'(in_rdy), 32'd1);
    @(posedge clk);
    #1;

    // Back-to-back ADD then SUB, one per cycle.
    opcode = OP_RR; funct3 = 3'b000; funct7_5 = 1'b0; funct7_0 = 1'b0;
    a = 32'h7FFF_FFFF; b = 32'h1; in_vld = 1'b1;
    @(negedge clk);
    chk("b2b_rdy_add", 32'(in_rdy), 32'd1);
    @(posedge clk);
    exp_q.push_back(32'h8000_0000); name_q.push_back("add");
    #1 funct7_5 = 1'b1; a = 32'h0; b = 32'h1;
    @(negedge clk);
    chk("b2b_rdy_sub", 32'(in_rdy), 32'd1);
    chk("b2b_vld_add", 32'(out_vld), 32'd1);
    @(posedge clk);
    exp_q.push_back(32'hFFFF_FFFF); name_q.push_back("sub");
    #1 in_vld = 1'b0;
    @(negedge clk);
    chk("b2b_vld_sub", 32'(out_vld), 32'd1);
    @(posedge clk);
    #1;

    // I-type sanity.
    run(OP_IMM, 3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'h4, 32'hF800_0000, "srai", 1);
    run(OP_IMM, 3'b000, 1'b0, 1'b0, 32'h5, 32'hFFFF_FFFF, 32'h4, "addi", 1);

    // Multiply: fixed latency 1+MUL_LAT.
    run(OP_RR, 3'b000, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE, "mul", 1 + MUL_LAT);
    run(OP_RR, 3'b001, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, "mulh", 1 + MUL_LAT);
    run(OP_RR, 3'b011, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, "mulhu", 1 + MUL_LAT);
    run(OP_RR, 3'b010, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, "mulhsu", 1 + MUL_LAT);

    // Iterative divide: latency 1+XLEN.
    run(OP_RR, 3'b100, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, "div", 1 + XLEN);
    run(OP_RR, 3'b110, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, "rem", 1 + XLEN);
    run(OP_RR, 3'b101, 1'b0, 1'b1, 32'd100, 32'd7, 32'd14, "divu", 1 + XLEN);
    run(OP_RR, 3'b111, 1'b0, 1'b1, 32'd100, 32'd7, 32'd2, "remu", 1 + XLEN);

    // Divide special cases resolve immediately.
    run(OP_RR, 3'b101, 1'b0, 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, "divu_z", 1);
    run(OP_RR, 3'b110, 1'b0, 1'b1, 32'd5, 32'd0, 32'd5, "rem_z", 1);
    run(OP_RR, 3'b100, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf", 1);
    run(OP_RR, 3'b110, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, "rem_ovf", 1);

    // Backpressure: result held while out_rdy=0.
    out_rdy = 1'b0;
    issue(OP_RR, 3'b001, 1'b0, 1'b0, 32'h1, 32'h25, 1'b1, 32'h20, "sll_bp");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_out_vld", 32'(out_vld), 32'd1);
      chk("bp_y", y, 32'h20);
      chk("bp_in_rdy", 32'(in_rdy), 32'd0);
    end
    @(posedge clk);
    #1 out_rdy = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;

    // Flush a divide ten cycles in.
    issue(OP_RR, 3'b101, 1'b0, 1'b1, 32'd100, 32'd7, 1'b0, 32'h0, "div_flush");
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_in_rdy_low", 32'(in_rdy), 32'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_in_rdy_high", 32'(in_rdy), 32'd1);
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_y_kept", y, 32'h20);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_vld) seen = 1'b1;
    end
    chk("flush_no_out_vld", 32'(seen), 32'd0);
    @(posedge clk);
    #1;

    // Reset in the middle of a multiply.
    issue(OP_RR, 3'b000, 1'b0, 1'b1, 32'd3, 32'd5, 1'b0, 32'h0, "mul_rst");
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mrst_out_vld", 32'(out_vld), 32'd0);
    chk("mrst_y", y, 32'h0);
    chk("mrst_busy", 32'(busy), 32'd0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_vld) seen = 1'b1;
    end
    chk("mrst_no_out_vld", 32'(seen), 32'd0);
    @(posedge clk);
    #1;

    // Branch compares.
    run(OP_BR, 3'b110, 1'b0, 1'b0, 32'h1, 32'hFFFF_FFFF, 32'h1, "bltu", 1);
    run(OP_BR, 3'b100, 1'b0, 1'b0, 32'h1, 32'hFFFF_FFFF, 32'h0, "blt", 1);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
